// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: the ALU result stream has strict priority,
// load results queue in an in-order FIFO, and a scoreboard reports pending writes.
module regfile_wb_arbiter #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [AW-1:0]            lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    output logic                     we,
    output logic [AW-1:0]            waddr,
    output logic [XLEN-1:0]          wdata,
    input  logic [AW-1:0]            chk_addr1,
    input  logic [AW-1:0]            chk_addr2,
    output logic                     chk_busy1,
    output logic                     chk_busy2,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   rd_q   [DEPTH];
    logic [AW-1:0]   rd_d   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic alu_req, push, pop;
    logic hit1, hit2;

    // lsu_valid/lsu_ready: a transfer occurs on every rising edge where both are
    // high; lsu_ready depends only on registered state (and rst), never on lsu_valid.
    assign lsu_ready  = !rst && (count_q < CW'(DEPTH));
    assign we         = we_q;
    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign fifo_count = count_q;

    always_comb begin
        alu_req = alu_valid && (alu_rd != '0);
        push    = lsu_valid && lsu_ready && (lsu_rd != '0);
        pop     = !alu_req && (count_q != '0);

        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (alu_req) begin
            we_d    = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end else if (pop && live_q[head_q]) begin
            we_d    = 1'b1;
            waddr_d = rd_q[head_q];
            wdata_d = data_q[head_q];
        end

        // Kill precedes the tail write so a same-cycle enqueue (younger) stays live.
        for (int i = 0; i < DEPTH; i++) begin
            rd_d[i]   = rd_q[i];
            data_d[i] = data_q[i];
            live_d[i] = live_q[i];
            if (alu_req && (rd_q[i] == alu_rd)) live_d[i] = 1'b0;
            if (pop && (PW'(i) == head_q))      live_d[i] = 1'b0;
            if (push && (PW'(i) == tail_q)) begin
                rd_d[i]   = lsu_rd;
                data_d[i] = lsu_data;
                live_d[i] = 1'b1;
            end
        end

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] == chk_addr1)) hit1 = 1'b1;
            if (live_q[i] && (rd_q[i] == chk_addr2)) hit2 = 1'b1;
        end
        chk_busy1 = (chk_addr1 != '0) && (hit1 || (we_q && (waddr_q == chk_addr1)));
        chk_busy2 = (chk_addr2 != '0) && (hit2 || (we_q && (waddr_q == chk_addr2)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= '0;
                data_q[i] <= '0;
            end
            live_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i]   <= rd_d[i];
                data_q[i] <= data_d[i];
            end
            live_q  <= live_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end
endmodule
